// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and constants for bus masters.
// Also holds the generic-bus bridge state encoding.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011
    } hburst_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_DONE = 2'b11
    } bridge_state_t;

endpackage

// File: rtl/ahb_size_decode.sv
// Byte-lane enable to AHB transfer size and low address bits.
// Irregular lane patterns fall back to a full aligned word.
module ahb_size_decode
    import ahb_pkg::*;
(
    input  logic [3:0] byte_en,
    output logic [2:0] hsize,
    output logic [1:0] offset
);

    // Map each legal lane pattern to its natural size and offset
    always_comb begin
        hsize  = HSIZE_WORD;
        offset = 2'b00;
        unique case (byte_en)
            4'b1111: begin hsize = HSIZE_WORD; offset = 2'b00; end
            4'b0011: begin hsize = HSIZE_HALF; offset = 2'b00; end
            4'b1100: begin hsize = HSIZE_HALF; offset = 2'b10; end
            4'b0001: begin hsize = HSIZE_BYTE; offset = 2'b00; end
            4'b0010: begin hsize = HSIZE_BYTE; offset = 2'b01; end
            4'b0100: begin hsize = HSIZE_BYTE; offset = 2'b10; end
            4'b1000: begin hsize = HSIZE_BYTE; offset = 2'b11; end
            default: begin hsize = HSIZE_WORD; offset = 2'b00; end
        endcase
    end

endmodule

// File: rtl/generic_bus_ahb_master.sv
// Generic ren/wen/busy bus to AHB-Lite master bridge.
// One held request becomes one non-pipelined SINGLE transfer.
module generic_bus_ahb_master
    import ahb_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter logic [3:0]  HPROT_VAL  = 4'b0011
)
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [3:0]            byte_en,
    input  logic                  ren,
    input  logic                  wen,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  bus_error,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic                  HWRITE,
    output logic [1:0]            HTRANS,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic                  HMASTLOCK,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    bridge_state_t         state;
    bridge_state_t         next_state;

    logic [2:0]            dec_hsize;
    logic [1:0]            dec_offset;

    logic [ADDR_WIDTH-1:0] haddr_q;
    logic                  hwrite_q;
    logic [2:0]            hsize_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  error_q;

    logic                  req;
    logic                  capture;
    logic                  data_done;
    logic [1:0]            htrans_c;
    logic                  busy_c;
    logic                  bus_error_c;

    // Low address bits come from the lane decode instead
    logic                  addr_lsb_unused;
    assign addr_lsb_unused = ^addr[1:0];

    assign req       = ren | wen;
    assign capture   = (state == ST_IDLE) && req;
    assign data_done = (state == ST_DATA) && HREADY;

    ahb_size_decode u_size_decode (
        .byte_en (byte_en),
        .hsize   (dec_hsize),
        .offset  (dec_offset)
    );

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: DONE never samples the request, so a request
    // changed in the busy-low cycle is only seen back in IDLE
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: if (req)    next_state = ST_ADDR;
            ST_ADDR: if (HREADY) next_state = ST_DATA;
            ST_DATA: if (HREADY) next_state = ST_DONE;
            ST_DONE:             next_state = ST_IDLE;
            default:             next_state = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; NONSEQ only in the address phase
    always_comb begin
        htrans_c    = HTRANS_IDLE;
        busy_c      = 1'b1;
        bus_error_c = 1'b0;
        unique case (state)
            ST_IDLE: ;
            ST_ADDR: htrans_c = HTRANS_NONSEQ;
            ST_DATA: ;
            ST_DONE: begin
                busy_c      = 1'b0;
                bus_error_c = error_q;
            end
            default: ;
        endcase
    end

    // Request capture: address-phase values held until HREADY
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= HSIZE_WORD;
            wdata_q  <= '0;
        end else if (capture) begin
            haddr_q  <= {addr[ADDR_WIDTH-1:2], dec_offset};
            hwrite_q <= wen;
            hsize_q  <= dec_hsize;
            wdata_q  <= wdata;
        end
    end

    // Data-phase completion: read data and error status
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdata_q <= '0;
            error_q <= 1'b0;
        end else if (data_done) begin
            if (hwrite_q || (HRESP == HRESP_ERROR)) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= HRDATA;
            end
            error_q <= (HRESP != HRESP_OKAY);
        end
    end

    assign rdata     = rdata_q;
    assign busy      = busy_c;
    assign bus_error = bus_error_c;

    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HTRANS    = htrans_c;
    assign HSIZE     = hsize_q;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = wdata_q;

endmodule

// File: doc/generic_bus_ahb_master.md
Name: generic_bus_ahb_master

Overview:
- Bridge from the single arbitrated generic bus produced by the memory controller to an AHB-Lite master port.
- Sits directly downstream of the I/D arbitration stage and upstream of the AHB interconnect.
- Converts one held ren/wen request into a single non-pipelined AHB transfer.
- Returns read data and completion through the generic bus busy handshake.

Parameters:
- ADDR_WIDTH, 32, generic-bus and HADDR width.
- DATA_WIDTH, 32, rdata/wdata/HRDATA/HWDATA width; only 32 supported.
- HPROT_VAL, 4'b0011, constant driven on HPROT.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- addr  in  ADDR_WIDTH  generic-bus word address; bits [1:0] ignored.
- wdata  in  32  write data, already endian-adjusted upstream.
- byte_en  in  4  byte lanes.
- ren  in  1  read request.
- wen  in  1  write request.
- rdata  out  32  read data; valid only while busy=0.
- busy  out  1  low for exactly one cycle per completed transfer.
- bus_error  out  1  high with busy=0 when the transfer got HRESP=ERROR.
- HADDR  out  ADDR_WIDTH  AHB address.
- HWRITE  out  1  AHB direction.
- HTRANS  out  2  IDLE=00 or NONSEQ=10 only.
- HSIZE  out  3  byte=000, half=001, word=010.
- HBURST  out  3  constant SINGLE=000.
- HPROT  out  4  HPROT_VAL.
- HMASTLOCK  out  1  constant 0.
- HWDATA  out  32  AHB write data.
- HRDATA  in  32  AHB read data.
- HREADY  in  1  AHB ready.
- HRESP  in  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset: state=IDLE, busy=1, bus_error=0, rdata=0, HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=010, HWDATA=0. RST asserted mid-transfer abandons the transfer; the interconnect is reset with it.
- Request priority: wen wins if ren and wen are both high (write, not read).
- IDLE: busy=1, HTRANS=IDLE. If ren|wen, register the following, then go to ADDR:
  - addr[ADDR_WIDTH-1:2]
  - byte_en-derived offset and HSIZE
  - write flag
  - wdata
- ADDR: drive HTRANS=NONSEQ plus registered HADDR/HWRITE/HSIZE; hold them stable while HREADY=0. When HREADY=1, go to DATA.
- DATA: HTRANS=IDLE; HWDATA=registered wdata. While HREADY=0, stay in DATA. When HREADY=1, latch HRDATA into rdata (0 on error) and latch error=HRESP, then go to DONE.
- DONE: busy=0 and bus_error=error for this cycle only; next state IDLE. Requests are not sampled in DONE, because upstream drops or changes its request the cycle after busy falls.
- Latency: request seen in cycle 0 with zero-wait slave gives busy=0 in cycle 3. Each wait state adds one cycle.
- Request withdrawn after capture (e.g. interrupt abort of an instruction fetch): the AHB transfer still completes, because AHB-Lite forbids retracting NONSEQ. DONE then pulses busy=0, which upstream ignores.
- Byte-enable decode:
  - 1111 → HSIZE=word, offset 00.
  - 0011 → half, offset 00.
  - 1100 → half, offset 10.
  - 0001/0010/0100/1000 → byte, offsets 00/01/10/11.
  - Any other pattern → word, offset 00.
  - HADDR = {addr[ADDR_WIDTH-1:2], offset}.
- Two-cycle AHB ERROR response: cycle 1 (HRESP=1, HREADY=0) waits; cycle 2 (HRESP=1, HREADY=1) completes. HTRANS is already IDLE in DATA, so no cancel logic is needed.
- Writes: rdata is 0 in DONE.

Decomposition:
- Shared package ahb_pkg:
  - htrans_t (IDLE, BUSY, NONSEQ, SEQ)
  - hsize_t
  - hburst_t
  - HRESP_OKAY/HRESP_ERROR constants
  - bridge state enum (IDLE, ADDR, DATA, DONE)
- Sub-module ahb_size_decode: combinational byte_en → {hsize, offset}. It is reused by future AHB masters.

Test Plan:
- Read, zero-wait: addr=0x0000_1000, byte_en=1111, ren=1 held; slave HRDATA=0xDEADBEEF. → HTRANS=10 with HADDR=0x1000, HSIZE=010 in cycle 1; busy=0, rdata=0xDEADBEEF in cycle 3.
- Write, 2 wait states: addr=0x2004, byte_en=1100, wdata=0x1234_0000, wen=1. → HADDR=0x2006, HSIZE=001, HWRITE=1, HWDATA=0x1234_0000 held through the waits; busy=0 in cycle 5.
- Error response: read with HRESP=1/HREADY=0, then HRESP=1/HREADY=1. → DONE gives busy=0, bus_error=1, rdata=0; next transfer gives bus_error=0.
- Abort: ren dropped in cycle 1 during ADDR with HREADY=0. → HTRANS/HADDR stay stable until HREADY; transfer completes; single busy=0 pulse; then IDLE with no new transfer.
- Back-to-back: instruction read, then data write requested the cycle after busy=0. → two distinct NONSEQ transfers, and no transfer is launched from the DONE-cycle request.
- Reset mid-DATA: RST=1 asynchronously. → outputs immediately return to reset values; state is IDLE after release.
